ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. It sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- It is the opposite direction to the existing scan-code receive path, and sits beside it on the same ps2c/ps2d pins.
- It drives both pins open-drain via output-enable signals. It performs the full request-to-send, data, parity, stop and acknowledge sequence.
- It reports completion or failure to the control logic.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_filter.sv | 58 +++++
 rtl/ps2_host_tx.sv | 194 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions used by the host transmit and device receive paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RTS,
    START,
    DATA,
    STOP,
    ACK,
    WAIT_IDLE
  } ps2_state_e;

  // Data byte plus parity shifted onto ps2d
  localparam int unsigned FRAME_BITS = 9;
  // Device clock fall on which the acknowledge bit is read
  localparam int unsigned ACK_FALL   = 11;

  // PS/2 parity bit: makes the total number of ones in byte+parity odd
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// PS/2 pin conditioning: 2-flop synchronisers on both pins, a debounce filter
// on the clock pin and a single-cycle pulse on each filtered clock fall.
module ps2_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_ps2c,
  input  logic i_ps2d,
  output logic o_ps2c_filt,
  output logic o_ps2d_sync,
  output logic o_fall
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic [1:0]       r_c_sync;
  logic [1:0]       r_d_sync;
  logic             r_filt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fall;

  // Synchronise both raw pins; idle bus level is high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_c_sync <= '1;
      r_d_sync <= '1;
    end else begin
      r_c_sync <= {r_c_sync[0], i_ps2c};
      r_d_sync <= {r_d_sync[0], i_ps2d};
    end
  end

  // Accept a new clock level only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_filt <= 1'b1;
      r_cnt  <= '0;
      r_fall <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (r_c_sync[1] == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
        r_filt <= r_c_sync[1];
        r_cnt  <= '0;
        r_fall <= r_filt;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_ps2c_filt = r_filt;
  assign o_ps2d_sync = r_d_sync[1];
  assign o_fall      = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, start, 8 data bits,
// odd parity, stop and acknowledge, driving both pins open-drain.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_e            r_state;
  ps2_state_e            w_next;
  logic [FRAME_BITS-1:0] r_frame;
  logic [3:0]            r_bit_cnt;
  logic [INH_W-1:0]      r_inh_cnt;
  logic [WD_W-1:0]       r_wdog;
  logic                  r_ps2d_oe;
  logic                  r_ok;
  logic                  r_err;
  logic                  r_tx_done;
  logic                  r_tx_err;

  logic w_ps2c_filt;
  logic w_ps2d_sync;
  logic w_fall;
  logic w_watch;
  logic w_timeout;
  logic w_load;
  logic w_shift;
  logic w_ps2d_oe_next;
  logic w_set_ok;
  logic w_set_err;
  logic w_done_pulse;
  logic w_err_pulse;

  ps2_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk         (clk),
    .reset       (reset),
    .i_ps2c      (ps2c_in),
    .i_ps2d      (ps2d_in),
    .o_ps2c_filt (w_ps2c_filt),
    .o_ps2d_sync (w_ps2d_sync),
    .o_fall      (w_fall)
  );

  assign w_watch   = (r_state == START) || (r_state == DATA) || (r_state == STOP) ||
                     (r_state == ACK)   || (r_state == WAIT_IDLE);
  assign w_timeout = w_watch && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and per-cycle control; the watchdog overrides any other action
  always_comb begin
    w_next         = r_state;
    w_load         = 1'b0;
    w_shift        = 1'b0;
    w_ps2d_oe_next = r_ps2d_oe;
    w_set_ok       = 1'b0;
    w_set_err      = 1'b0;
    w_done_pulse   = 1'b0;
    w_err_pulse    = 1'b0;
    case (r_state)
      IDLE: begin
        w_ps2d_oe_next = 1'b0;
        if (wr_ps2) begin
          w_load = 1'b1;
          w_next = RTS;
        end
      end
      RTS: begin
        w_ps2d_oe_next = 1'b0;
        if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
          w_ps2d_oe_next = 1'b1;
          w_next         = START;
        end
      end
      START: begin
        if (w_fall) begin
          w_ps2d_oe_next = ~r_frame[0];
          w_shift        = 1'b1;
          w_next         = DATA;
        end
      end
      DATA: begin
        if (w_fall) begin
          w_ps2d_oe_next = ~r_frame[0];
          w_shift        = 1'b1;
          if (r_bit_cnt == 4'(FRAME_BITS - 1)) w_next = STOP;
        end
      end
      STOP: begin
        if (w_fall) begin
          w_ps2d_oe_next = 1'b0;
          w_next         = ACK;
        end
      end
      ACK: begin
        if (w_fall) begin
          w_set_ok  = ~w_ps2d_sync;
          w_set_err = w_ps2d_sync;
          w_next    = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (w_ps2d_sync && w_ps2c_filt) begin
          w_done_pulse = r_ok;
          w_err_pulse  = r_err;
          w_next       = IDLE;
        end
      end
      default: begin
        w_ps2d_oe_next = 1'b0;
        w_next         = IDLE;
      end
    endcase
    if (w_timeout) begin
      w_next         = IDLE;
      w_ps2d_oe_next = 1'b0;
      w_shift        = 1'b0;
      w_set_ok       = 1'b0;
      w_set_err      = 1'b0;
      w_done_pulse   = 1'b0;
      w_err_pulse    = 1'b1;
    end
  end

  // Frame shifter, fall counter, result flags and registered pin/status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame   <= '0;
      r_bit_cnt <= '0;
      r_ok      <= 1'b0;
      r_err     <= 1'b0;
      r_ps2d_oe <= 1'b0;
      r_tx_done <= 1'b0;
      r_tx_err  <= 1'b0;
    end else begin
      r_ps2d_oe <= w_ps2d_oe_next;
      r_tx_done <= w_done_pulse;
      r_tx_err  <= w_err_pulse;
      if (w_load) begin
        r_frame   <= {odd_parity(din), din};
        r_bit_cnt <= '0;
        r_ok      <= 1'b0;
        r_err     <= 1'b0;
      end else begin
        if (w_shift) r_frame <= {1'b0, r_frame[FRAME_BITS-1:1]};
        if (w_fall && w_watch && (r_state != WAIT_IDLE) && (r_bit_cnt != 4'(ACK_FALL)))
          r_bit_cnt <= r_bit_cnt + 1'b1;
        if (w_set_ok)  r_ok  <= 1'b1;
        if (w_set_err) r_err <= 1'b1;
      end
    end
  end

  // Inhibit timer runs only while in RTS; watchdog restarts on every fall or state change
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inh_cnt <= '0;
      r_wdog    <= '0;
    end else begin
      r_inh_cnt <= (r_state == RTS && w_next == RTS) ? r_inh_cnt + 1'b1 : '0;
      r_wdog    <= (w_watch && !w_fall && w_next == r_state) ? r_wdog + 1'b1 : '0;
    end
  end

  assign ps2c_oe = (r_state == RTS);
  assign ps2d_oe = r_ps2d_oe;
  assign tx_idle = (r_state == IDLE);
  assign tx_done = r_tx_done;
  assign tx_err  = r_tx_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 keyboard clocks the frame out,
// samples data on its rising clock edges and optionally acknowledges.
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = '0;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, tx_idle, tx_done, tx_err;

  logic dev_c_low = 1'b0;
  logic dev_d_low = 1'b0;
  logic glitch_low = 1'b0;

  // Open-drain bus with pull-ups
  assign ps2c_in = ~(ps2c_oe | dev_c_low | glitch_low);
  assign ps2d_in = ~(ps2d_oe | dev_d_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (20),
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (2000)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_ps2  (wr_ps2),
    .din     (din),
    .ps2c_in (ps2c_in),
    .ps2d_in (ps2d_in),
    .ps2c_oe (ps2c_oe),
    .ps2d_oe (ps2d_oe),
    .tx_idle (tx_idle),
    .tx_done (tx_done),
    .tx_err  (tx_err)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int n_done = 0;
  int n_errp = 0;
  int n_both = 0;
  bit last_idle = 1'b0;

  // Pulse monitor
  always @(negedge clk) begin
    if (tx_done) begin
      n_done++;
      last_idle = ps2c_in & ps2d_in & tx_idle;
    end
    if (tx_err) n_errp++;
    if (tx_done && tx_err) n_both++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: what the device should see on its 11 rising edges
  function automatic logic [10:0] model_bits(input logic [7:0] d);
    int   ones;
    logic par;
    ones = $countones(d);
    par  = (ones % 2 == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  typedef struct {
    logic [7:0]  din;
    bit          ack;
    bit          glitch;
    bit          busy;
    logic [10:0] exp_bits;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  task automatic strobe(input logic [7:0] d);
    @(negedge clk);
    din    = d;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
  endtask

  // Wait for the inhibit window; returns its length in cycles (-1 if it never came)
  task automatic wait_rts(output int len);
    int w;
    w   = 0;
    len = 0;
    while (!ps2c_oe && w < 10) begin tick(1); w++; end
    if (!ps2c_oe) begin len = -1; return; end
    while (ps2c_oe && len < 200) begin tick(1); len++; end
  endtask

  task automatic run_txn(input string tag, input logic [7:0] d, input bit ack,
                         input bit glitch, input bit busy,
                         input logic [10:0] exp_bits, input bit exp_done, input bit exp_err);
    logic [10:0] got;
    int          rts_len;
    int          d0, e0;
    got = '1;
    d0  = n_done;
    e0  = n_errp;
    strobe(d);
    wait_rts(rts_len);
    check({tag, " rts_len"}, rts_len, 20);
    if (rts_len < 0) return;
    tick(5);
    got[0] = ps2d_in;
    for (int k = 1; k <= 11; k++) begin
      dev_c_low = 1'b1;
      tick(40);
      dev_c_low = 1'b0;
      tick(1);
      if (k <= 10) got[k] = ps2d_in;
      for (int j = 1; j <= 39; j++) begin
        if (k == 11 && j == 1) dev_d_low = 1'b0;
        if (glitch && k == 4 && j == 15) glitch_low = 1'b1;
        if (glitch && k == 4 && j == 17) glitch_low = 1'b0;
        if (busy && k == 3 && j == 10) begin
          check({tag, " busy_idle"}, tx_idle, 0);
          din    = 8'hFF;
          wr_ps2 = 1'b1;
        end
        if (busy && k == 3 && j == 11) begin
          wr_ps2 = 1'b0;
          din    = d;
        end
        if (ack && k == 10 && j == 20) dev_d_low = 1'b1;
        tick(1);
      end
    end
    dev_d_low = 1'b0;
    tick(100);
    check({tag, " bits"}, got, exp_bits);
    check({tag, " done"}, n_done - d0, exp_done);
    check({tag, " err"}, n_errp - e0, exp_err);
    if (exp_done) check({tag, " lines_idle_at_done"}, last_idle, 1);
    check({tag, " idle_after"}, {ps2c_oe, ps2d_oe, tx_idle}, 3'b001);
  endtask

  vec_t vecs[4];

  initial begin
    int          cnt;
    int          d0, e0;
    logic [7:0]  rd;
    bit          rack;

    vecs[0] = '{din: 8'hED, ack: 1'b1, glitch: 1'b0, busy: 1'b0,
                exp_bits: 11'b1_1_11101101_0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{din: 8'h00, ack: 1'b0, glitch: 1'b0, busy: 1'b0,
                exp_bits: 11'b1_1_00000000_0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[2] = '{din: 8'h01, ack: 1'b1, glitch: 1'b1, busy: 1'b1,
                exp_bits: 11'b1_0_00000001_0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[3] = '{din: 8'h5A, ack: 1'b1, glitch: 1'b1, busy: 1'b1,
                exp_bits: 11'b1_1_01011010_0, exp_done: 1'b1, exp_err: 1'b0};

    // Reset state
    tick(3);
    check("rst ps2c_oe", ps2c_oe, 0);
    check("rst ps2d_oe", ps2d_oe, 0);
    check("rst tx_idle", tx_idle, 1);
    check("rst tx_done", tx_done, 0);
    check("rst tx_err", tx_err, 0);
    reset = 1'b1;
    tick(5);

    // Directed vectors
    for (int i = 0; i < 4; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].din, vecs[i].ack, vecs[i].glitch,
              vecs[i].busy, vecs[i].exp_bits, vecs[i].exp_done, vecs[i].exp_err);

    // Random bytes against the reference model
    for (int i = 0; i < 8; i++) begin
      rd   = 8'($urandom);
      rack = 1'($urandom_range(0, 1));
      run_txn($sformatf("rnd%0d_%02h", i, rd), rd, rack, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), model_bits(rd), rack, !rack);
    end

    // Timeout: device never clocks
    d0 = n_done;
    e0 = n_errp;
    strobe(8'h3C);
    wait_rts(cnt);
    check("to rts_len", cnt, 20);
    cnt = 0;
    while (!tx_err && cnt < 3000) begin
      tick(1);
      cnt++;
      if (cnt == 100) check("to start_bit_driven", ps2d_oe, 1);
    end
    check("to cycles", cnt, 2000);
    check("to lines", {ps2c_oe, ps2d_oe, tx_idle}, 3'b001);
    tick(5);
    check("to err_pulses", n_errp - e0, 1);
    check("to done_pulses", n_done - d0, 0);

    // Asynchronous reset mid-DATA
    strobe(8'h00);
    wait_rts(cnt);
    check("rstmid rts_len", cnt, 20);
    for (int k = 1; k <= 3; k++) begin
      dev_c_low = 1'b1;
      tick(40);
      dev_c_low = 1'b0;
      tick(40);
    end
    check("rstmid pre_ps2d_oe", ps2d_oe, 1);
    check("rstmid pre_idle", tx_idle, 0);
    #3;
    reset = 1'b0;
    #1;
    check("rstmid lines", {ps2c_oe, ps2d_oe, tx_idle}, 3'b001);
    tick(3);
    d0 = n_done;
    e0 = n_errp;
    reset = 1'b1;
    tick(200);
    check("rstmid no_done", n_done - d0, 0);
    check("rstmid no_err", n_errp - e0, 0);
    check("rstmid idle", tx_idle, 1);

    check("never_both", n_both, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
